// File: rtl/sram_arbiter.sv
// sram_arbiter
//
// Shares one synchronous SRAM, reached through sram_interface, between two
// requesters: the display read path and the capture write path. Reads win
// arbitration, but once MAX_RD_BURST reads in a row have been granted while a
// write is waiting, the write gets the next slot. At most one registered
// command is issued per cycle. Read data comes back in issue order after a
// fixed READ_LATENCY.
//
// Ports
//   clk, reset        single clock; synchronous active-high reset
//   rd_req/rd_addr    read request (held until rd_ack) and its address
//   rd_ack            combinational: read accepted at this clock edge
//   rd_data/rd_valid  returned read word and its one-cycle strobe
//   wr_req/wr_addr/wr_data  write request (held until wr_ack), address, data
//   wr_ack            combinational: write accepted at this clock edge
//   mem_addr, mem_data_out, mem_write_enable  registered command to sram_interface
//   mem_data_in       read data from sram_interface
module sram_arbiter #(
  parameter int ADDR_WIDTH   = 20,
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = 2,
  parameter int MAX_RD_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ack,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  wr_req,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_data_out,
  output logic                  mem_write_enable,
  input  logic [DATA_WIDTH-1:0] mem_data_in
);

  localparam int CNT_WIDTH = $clog2(MAX_RD_BURST + 1);
  localparam logic [CNT_WIDTH-1:0] BURST_MAX = CNT_WIDTH'(MAX_RD_BURST);

  typedef enum logic [1:0] {
    GRANT_IDLE,
    GRANT_READ,
    GRANT_WRITE
  } grant_t;

  grant_t                  grant;
  logic [CNT_WIDTH-1:0]    burst_cnt;
  // One bit per in-flight command; a 1 marks a real read whose data must be
  // returned. Idle slots also read the SRAM, but their data is discarded.
  logic [READ_LATENCY-1:0] valid_pipe;

  // Arbitration is combinational so a request can be accepted in the same
  // cycle it appears. Reset gates both acks, so nothing is accepted during reset.
  always_comb begin
    // NOTE: default assigned first so every path drives grant; no latch.
    grant = GRANT_IDLE;
    if (!reset) begin
      if (rd_req && (!wr_req || burst_cnt < BURST_MAX)) begin
        grant = GRANT_READ;
      end else if (wr_req) begin
        grant = GRANT_WRITE;
      end
    end
  end

  assign rd_ack = (grant == GRANT_READ);
  assign wr_ack = (grant == GRANT_WRITE);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register update sampling
    // pre-edge values, matching the hardware regardless of statement order.
    if (reset) begin
      burst_cnt        <= '0;
      valid_pipe       <= '0;
      mem_addr         <= '0;
      mem_data_out     <= '0;
      mem_write_enable <= 1'b0;
      rd_data          <= '0;
      rd_valid         <= 1'b0;
    end else begin
      // The burst count only matters while a write is waiting; any write
      // grant or an absent write request starts a fresh burst.
      if (!wr_req || grant == GRANT_WRITE) begin
        burst_cnt <= '0;
      end else if (grant == GRANT_READ && burst_cnt != BURST_MAX) begin
        burst_cnt <= burst_cnt + CNT_WIDTH'(1);
      end

      unique case (grant)
        GRANT_READ: begin
          mem_addr         <= rd_addr;
          mem_write_enable <= 1'b0;
        end
        GRANT_WRITE: begin
          mem_addr         <= wr_addr;
          mem_data_out     <= wr_data;
          mem_write_enable <= 1'b1;
        end
        default: begin
          mem_write_enable <= 1'b0;
        end
      endcase

      valid_pipe <= (valid_pipe << 1) | READ_LATENCY'(grant == GRANT_READ);

      if (valid_pipe[READ_LATENCY-1]) begin
        rd_data  <= mem_data_in;
        rd_valid <= 1'b1;
      end else begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//
// Directed bench for sram_arbiter with default parameters. A small SRAM
// model returns a fixed function of the read address READ_LATENCY cycles
// after the command; returned words are collected and compared against
// hand-computed expectations.
module tb_sram_arbiter;

  localparam int AW = 20;
  localparam int DW = 18;
  localparam int RL = 2;
  localparam int MB = 8;

  logic          clk;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_ack;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          wr_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data_out;
  logic          mem_write_enable;
  logic [DW-1:0] mem_data_in;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [DW-1:0] got_q[$];
  int            vcyc_q[$];
  logic [AW-1:0] addr_pipe[RL-1];

  sram_arbiter #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .READ_LATENCY(RL),
    .MAX_RD_BURST(MB)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rd_req          (rd_req),
    .rd_addr         (rd_addr),
    .rd_ack          (rd_ack),
    .rd_data         (rd_data),
    .rd_valid        (rd_valid),
    .wr_req          (wr_req),
    .wr_addr         (wr_addr),
    .wr_data         (wr_data),
    .wr_ack          (wr_ack),
    .mem_addr        (mem_addr),
    .mem_data_out    (mem_data_out),
    .mem_write_enable(mem_write_enable),
    .mem_data_in     (mem_data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM model: the address presented after edge N is captured at edge N+1
  // and its data is on mem_data_in in time to be sampled at edge N+RL.
  function automatic logic [DW-1:0] model_data(input logic [AW-1:0] a);
    logic [AW-1:0] x;
    if (a == 20'h00005) return 18'h2A5A5;
    x = a ^ 20'h00155;
    return x[DW-1:0];
  endfunction

  always @(posedge clk) begin
    addr_pipe[0] <= mem_addr;
    for (int i = 1; i < RL - 1; i++) addr_pipe[i] <= addr_pipe[i-1];
  end
  assign mem_data_in = model_data(addr_pipe[RL-2]);

  // Collect returned words (and the edge count they followed) on the falling edge.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      got_q.push_back(rd_data);
      vcyc_q.push_back(cyc);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_returns();
    got_q.delete();
    vcyc_q.delete();
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    rd_req  = 1'b1;
    wr_req  = 1'b1;
    rd_addr = 20'h0ABCD;
    wr_addr = 20'h01234;
    wr_data = 18'h15555;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (rd_ack !== 1'b0 || wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL reset_acks cycle %0d: rd_ack=%b wr_ack=%b, required 0 0", i, rd_ack, wr_ack);
      end
      step();
    end
    checks++;
    if (mem_addr !== '0 || mem_data_out !== '0 || mem_write_enable !== 1'b0 || rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: mem_addr=%h mem_data_out=%h we=%b rd_valid=%b, required all 0",
               mem_addr, mem_data_out, mem_write_enable, rd_valid);
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    reset  = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    int grant_edge;
    clear_returns();
    rd_req  = 1'b1;
    rd_addr = 20'h00005;
    #1;
    grant_edge = cyc + 1;
    checks++;
    if (rd_ack !== 1'b1 || wr_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_read_ack: rd_ack=%b wr_ack=%b, required 1 0", rd_ack, wr_ack);
    end
    step();
    rd_req = 1'b0;
    checks++;
    if (mem_addr !== 20'h00005 || mem_write_enable !== 1'b0) begin
      errors++;
      $display("FAIL single_read_cmd: mem_addr=%h we=%b, required 00005 0", mem_addr, mem_write_enable);
    end
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (got_q.size() !== 1) begin
      errors++;
      $display("FAIL single_read_count: %0d rd_valid strobes, required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0] !== 18'h2A5A5) begin
        errors++;
        $display("FAIL single_read_data: rd_data=%h, required 2a5a5", got_q[0]);
      end
      checks++;
      if (vcyc_q[0] !== grant_edge + RL) begin
        errors++;
        $display("FAIL single_read_latency: rd_valid after edge %0d, required after edge %0d",
                 vcyc_q[0], grant_edge + RL);
      end
    end
  endtask

  task automatic test_single_write();
    clear_returns();
    rd_req  = 1'b0;
    wr_req  = 1'b1;
    wr_addr = 20'h12345;
    wr_data = 18'h3FFFF;
    #1;
    checks++;
    if (wr_ack !== 1'b1 || rd_ack !== 1'b0) begin
      errors++;
      $display("FAIL single_write_ack: wr_ack=%b rd_ack=%b, required 1 0", wr_ack, rd_ack);
    end
    step();
    wr_req = 1'b0;
    checks++;
    if (mem_addr !== 20'h12345 || mem_data_out !== 18'h3FFFF || mem_write_enable !== 1'b1) begin
      errors++;
      $display("FAIL single_write_cmd: mem_addr=%h mem_data_out=%h we=%b, required 12345 3ffff 1",
               mem_addr, mem_data_out, mem_write_enable);
    end
    step();
    checks++;
    if (mem_write_enable !== 1'b0 || mem_addr !== 20'h12345) begin
      errors++;
      $display("FAIL idle_after_write: we=%b mem_addr=%h, required 0 12345", mem_write_enable, mem_addr);
    end
    for (int i = 0; i < 4; i++) step();
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL single_write_no_valid: %0d rd_valid strobes, required 0", got_q.size());
    end
  endtask

  task automatic test_starvation();
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] ra;
    int            nrd = 0;
    int            nwr = 0;
    logic          exp_rd;
    clear_returns();
    rd_req = 1'b1;
    wr_req = 1'b1;
    for (int i = 0; i < 27; i++) begin
      ra      = 20'h00200 + AW'(nrd);
      rd_addr = ra;
      wr_addr = 20'h00300 + AW'(nwr);
      wr_data = 18'h10000 + DW'(nwr);
      exp_rd  = (i % 9) < 8;
      #1;
      checks++;
      if (rd_ack !== exp_rd || wr_ack !== !exp_rd) begin
        errors++;
        $display("FAIL starvation_grant %0d: rd_ack=%b wr_ack=%b, required %b %b",
                 i, rd_ack, wr_ack, exp_rd, !exp_rd);
      end
      step();
      if (exp_rd) begin
        exp_q.push_back(model_data(ra));
        nrd++;
      end else begin
        checks++;
        if (mem_write_enable !== 1'b1 || mem_addr !== 20'h00300 + AW'(nwr)) begin
          errors++;
          $display("FAIL starvation_write_cmd %0d: we=%b mem_addr=%h, required 1 %h",
                   nwr, mem_write_enable, mem_addr, 20'h00300 + AW'(nwr));
        end
        nwr++;
      end
    end
    rd_req = 1'b0;
    wr_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (got_q.size() !== 24) begin
      errors++;
      $display("FAIL starvation_read_count: %0d returns, required 24", got_q.size());
    end else begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL starvation_read_data %0d: rd_data=%h, required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] exp[4];
    exp[0] = 18'h055;
    exp[1] = 18'h054;
    exp[2] = 18'h057;
    exp[3] = 18'h056;
    clear_returns();
    rd_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 20'h00100 + AW'(i);
      #1;
      checks++;
      if (rd_ack !== 1'b1) begin
        errors++;
        $display("FAIL stream_ack %0d: rd_ack=%b, required 1", i, rd_ack);
      end
      step();
    end
    rd_req = 1'b0;
    for (int i = 0; i < 6; i++) step();
    checks++;
    if (got_q.size() !== 4) begin
      errors++;
      $display("FAIL stream_count: %0d returns, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] !== exp[i] || vcyc_q[i] !== vcyc_q[0] + i) begin
          errors++;
          $display("FAIL stream_data %0d: rd_data=%h after edge %0d, required %h after edge %0d",
                   i, got_q[i], vcyc_q[i], exp[i], vcyc_q[0] + i);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    clear_returns();
    rd_req = 1'b1;
    for (int i = 0; i < 2; i++) begin
      rd_addr = 20'h00020 + AW'(i);
      #1;
      checks++;
      if (rd_ack !== 1'b1) begin
        errors++;
        $display("FAIL midflight_ack %0d: rd_ack=%b, required 1", i, rd_ack);
      end
      step();
    end
    rd_req = 1'b0;
    reset  = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (got_q.size() !== 0) begin
      errors++;
      $display("FAIL midflight_no_valid: %0d rd_valid strobes, required 0", got_q.size());
    end
    rd_req  = 1'b1;
    rd_addr = 20'h00042;
    #1;
    checks++;
    if (rd_ack !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ack: rd_ack=%b, required 1", rd_ack);
    end
    step();
    rd_req = 1'b0;
    for (int i = 0; i < 5; i++) step();
    checks++;
    if (got_q.size() !== 1 || got_q[0] !== 18'h117) begin
      errors++;
      $display("FAIL post_reset_read: %0d returns, first=%h, required 1 return of 117",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : 18'h0);
    end
  endtask

  initial begin
    reset   = 1'b1;
    rd_req  = 1'b0;
    wr_req  = 1'b0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
    #1;
    test_reset();
    test_single_read();
    test_single_write();
    test_starvation();
    test_back_to_back();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
